// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv
//   Shared rv32 pipeline types and constants.
//     pc_t    : word address into instruction memory (512 words)
//     ir_t    : raw 32-bit instruction word
//     data_t  : memory data word
//     NOP     : canonical no-op (addi x0, x0, 0)
//     INIT_PC : word address fetched first out of reset
// ----------------------------------------------------------------------------
package riscv;

    typedef logic [8:0]  pc_t;
    typedef logic [31:0] ir_t;
    typedef logic [31:0] data_t;

    localparam ir_t NOP     = 32'h0000_0013;
    localparam pc_t INIT_PC = 9'h000;

endpackage

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch for the rv32 pipeline. Owns the program counter, drives
//   a synchronous (1-cycle latency) instruction memory and presents the
//   fetched word, its pc and a valid flag to decode. A killed slot reads as
//   NOP.
//
//   Build option FETCH_HOLD_EN:
//     undefined : the memory output is assumed to hold while imem_en=0, so
//                 the instruction is always taken straight from imem_data.
//     defined   : a small run/hold FSM captures the instruction when a stall
//                 begins and replays it until the stall ends, so the memory
//                 output may change freely while stalled.
//
//   Ports
//     clk          in   clock, all state on rising edge
//     reset        in   synchronous, active-high
//     stall        in   hold pc and the decode-facing output
//     flush        in   kill the instruction arriving at decode next cycle
//     redirect     in   taken branch / jump from execute
//     redirect_pc  in   target word address when redirect=1
//     imem_en      out  memory read enable
//     imem_addr    out  read word address (combinational next pc)
//     imem_data    in   read data, valid the cycle after imem_en=1
//     id_ir        out  instruction to decode
//     id_pc        out  word address of id_ir
//     id_valid     out  id_ir is a live instruction
// ----------------------------------------------------------------------------
module fetch_stage
    import riscv::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  pc_t   redirect_pc,
    output logic  imem_en,
    output pc_t   imem_addr,
    input  data_t imem_data,
    output ir_t   id_ir,
    output pc_t   id_pc,
    output logic  id_valid
);

    pc_t  pc_q,    pc_d;
    logic valid_q, valid_d;
    ir_t  instr_src;

    // Next-pc mux. During reset INIT_PC is presented to the memory so its
    // word is already on imem_data in the first cycle after release.
    always_comb begin
        pc_d = pc_q + pc_t'(1);
        if (reset) begin
            pc_d = INIT_PC;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    assign imem_addr = pc_d;
    assign imem_en   = reset | redirect | ~stall;

    // flush outranks redirect and stall; a stall keeps a killed slot killed.
    always_comb begin
        valid_d = 1'b1;
        if (reset) begin
            valid_d = 1'b1;
        end else if (flush) begin
            valid_d = 1'b0;
        end else if (redirect) begin
            valid_d = 1'b1;
        end else if (stall) begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= INIT_PC;
            valid_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_HOLD_EN
    // state  | meaning
    // S_RUN  | instruction comes straight from imem_data
    // S_HOLD | stalled; instruction replayed from hold_q
    typedef enum logic {S_RUN, S_HOLD} state_e;

    state_e state_q, state_d;
    ir_t    hold_q,  hold_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        instr_src = ir_t'(imem_data);
        case (state_q)
            S_RUN: begin
                // First stalled cycle: imem_data is still good, grab it
                // before the memory is clocked with imem_en=0.
                if (stall && !redirect && !flush) begin
                    state_d = S_HOLD;
                    hold_d  = ir_t'(imem_data);
                end
            end
            S_HOLD: begin
                instr_src = hold_q;
                if (!stall || redirect || flush) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            hold_q  <= NOP;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end
`else
    assign instr_src = ir_t'(imem_data);
`endif

    assign id_pc    = pc_q;
    assign id_valid = valid_q;
    assign id_ir    = valid_q ? instr_src : NOP;

endmodule
